ppt_regfile_mc: RTL and testbench
=================================

// Module: ppt_regfile_mc
// PURPOSE
//  Multi-channel byte-wide register file between the I2C slave and N_CH PPT pulse controllers.
//  Adds the following over the single-channel map:
//   - atomic 16-bit config writes
//   - snapshot reads of 16-bit counters
//   - sticky W1C done flags
//   - run auto-stop
//   - write protection while a channel runs
//   - a global enable
//   - optional interrupt
// PARAMETERS
//  N_CH    2  number of PPT channels; (N_CH+1)*16 <= 2**ADDR_W (checked at elaboration)
//  ADDR_W  6  byte address width
//  DIV_W   5  clock-divider field width (1..8)
// PORTS
//  clk            in   1         system clock
//  rstn           in   1         async active-low reset
//  address        in   ADDR_W    byte address from I2C slave
//  data_in        in   8         write data
//  write_enable   in   1         1-cycle write strobe
//  read_enable    in   1         1-cycle read strobe (side effects only)
//  data_out       out  8         registered read data
//  ch_clk_div     out  N_CH*DIV_W  per-channel divider, ch c at [c*DIV_W +: DIV_W]
//  ch_period      out  N_CH*16   per-channel period
//  ch_width       out  N_CH*16   per-channel pulse width
//  ch_count       out  N_CH*16   per-channel firing count
//  ch_run         out  N_CH      effective run = CTRL.RUN & GCTRL.GEN
//  ch_count_done  in   N_CH*16   firings completed (same clock domain)
//  ch_done        in   N_CH      channel finished (level)
//  irq            out  1         interrupt (0 unless PPT_REGFILE_IRQ_EN)
// BEHAVIOUR
//  Clock and reset:
//   - One clock: clk. Reset is asynchronous and active-low: rstn.
//   - Every register and output is reset on rstn low.
//  Global map:
//   - 0x00 ID (RO) = {4'hA, N_CH[3:0]}
//   - 0x01 GCTRL: bit0 GEN, reset 1
//   - 0x02 IRQ_MASK: bits[N_CH-1:0], reset 0
//   - 0x03 IRQ_STAT: OR-view of sticky flags (RO)
//   - 0x04-0x0F read 0.
//  Channel block: channel c is based at 16*(c+1).
//   - +0 CLK_DIV, reset 9
//   - +1/+2 PERIOD_L/H, reset 128
//   - +3/+4 WIDTH_L/H, reset 1
//   - +5/+6 COUNT_L/H, reset 16
//   - +7 CTRL: bit0 RUN, bit1 AUTOSTOP; reset 0
//   - +8/+9 CNT_DONE_L/H (RO)
//   - +A STATUS: bit0 DONE live, bit1 STICKY (W1C)
//   - +B-+F reserved, read 0, writes ignored
//  Unmapped addresses: read 0, writes ignored.
//  Writes:
//   - *_L writes go to a per-channel holding byte.
//   - *_H writes commit {data_in, hold} to the live 16-bit field in one cycle.
//   - The outputs therefore never show a half-updated value.
//   - While ch_run[c]=1, writes to +0..+6 of channel c are ignored (holding byte included).
//   - CTRL and STATUS remain writable while running.
//  Reads:
//   - data_out updates 1 cycle after address; it is combinationally independent of read_enable.
//   - read_enable at CNT_DONE_L latches count_done[15:8] into a snapshot register.
//   - CNT_DONE_H returns the snapshot, never the live value.
//   - STICKY is set on a 0->1 edge of ch_done[c], using a registered previous value.
//   - Writing 1 to STATUS bit1 clears STICKY.
//   - Simultaneous set and clear: set wins.
//  Auto-stop:
//   - A done rising edge with AUTOSTOP=1 clears RUN the next cycle.
//   - A host CTRL write in that same cycle wins: the written value is kept.
//  GEN=0 forces every ch_run low without altering CTRL.RUN. Restoring GEN=1 resumes with the stored RUN.
//  Reset mid-operation: all fields return to defaults and ch_run drops immediately (async).
// CONFIGURATION
//  PPT_REGFILE_IRQ_EN defined:
//   - irq is registered: irq = |(STICKY & IRQ_MASK).
//   - irq deasserts the cycle after the last masked sticky flag is cleared.
//   - IRQ_MASK is writable.
//  PPT_REGFILE_IRQ_EN undefined:
//   - irq tied 0.
//   - 0x02 and 0x03 read 0; writes to them are ignored.
// TESTING
//  1. Reset, read 0x00, 0x10, 0x11, 0x17 -> 8'hA2, 9, 128, 0; ch_period[15:0]=128; ch_run=0.
//  2. Write 0x13=0x34 -> ch_width[15:0] unchanged (1). Then write 0x14=0x12 -> ch_width[15:0]=16'h1234 one cycle later.
//  3. Write 0x17=0x03, then write 0x11=0x55 -> period unchanged. Pulse ch_done[0] -> RUN clears, STICKY=1, STATUS reads 0x03.
//  4. ch_count_done[15:0]=16'h01FF, read 0x18, change input to 16'h0200, read 0x19 -> 0xFF then 0x01.
//  5. Write 0x01=0 -> ch_run=0 with CTRL.RUN=1 still readable. Write 0x01=1 -> ch_run[0]=1.
//  6. IRQ_EN: mask=0x01, done edge ch0 -> irq=1; write 0x1A=0x02 -> irq=0; done edge coincident with W1C -> STICKY stays 1.

Source files
------------

// File: rtl/ppt_regfile_mc.sv
// ppt_regfile_mc: multi-channel byte-wide register file sitting between the
// I2C slave and N_CH PPT pulse controllers.
//  - 16-bit fields are committed atomically on the high-byte write
//  - CNT_DONE_H returns a snapshot latched by a read strobe at CNT_DONE_L
//  - sticky W1C done flags, run auto-stop, config write protection while running
//  - global enable gating every channel's run output
// Optional feature macro: PPT_REGFILE_IRQ_EN (irq output, IRQ_MASK/IRQ_STAT registers).
module ppt_regfile_mc #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     address,
    input  logic [7:0]            data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [7:0]            data_out,
    output logic [N_CH*DIV_W-1:0] ch_clk_div,
    output logic [N_CH*16-1:0]    ch_period,
    output logic [N_CH*16-1:0]    ch_width,
    output logic [N_CH*16-1:0]    ch_count,
    output logic [N_CH-1:0]       ch_run,
    input  logic [N_CH*16-1:0]    ch_count_done,
    input  logic [N_CH-1:0]       ch_done,
    output logic                  irq
);

    // Elaboration-time parameter checks
    if ((N_CH + 1) * 16 > 2 ** ADDR_W) begin : g_chk_addr
        $error("ppt_regfile_mc: (N_CH+1)*16 does not fit in 2**ADDR_W");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_chk_nch
        $error("ppt_regfile_mc: N_CH must be 1..8 (one byte of flag/mask bits)");
    end
    if (DIV_W < 1 || DIV_W > 8) begin : g_chk_div
        $error("ppt_regfile_mc: DIV_W must be 1..8");
    end

    localparam int BLK_W = ADDR_W - 4;

    // Global register offsets (block 0)
    typedef enum logic [3:0] {
        G_ID       = 4'h0,
        G_GCTRL    = 4'h1,
        G_IRQ_MASK = 4'h2,
        G_IRQ_STAT = 4'h3
    } glb_off_e;

    // Per-channel register offsets
    typedef enum logic [3:0] {
        OFF_CLK_DIV  = 4'h0,
        OFF_PERIOD_L = 4'h1,
        OFF_PERIOD_H = 4'h2,
        OFF_WIDTH_L  = 4'h3,
        OFF_WIDTH_H  = 4'h4,
        OFF_COUNT_L  = 4'h5,
        OFF_COUNT_H  = 4'h6,
        OFF_CTRL     = 4'h7,
        OFF_CDONE_L  = 4'h8,
        OFF_CDONE_H  = 4'h9,
        OFF_STATUS   = 4'hA
    } ch_off_e;

    logic [BLK_W-1:0]      blk;
    logic [3:0]            offset;
    logic                  glb_sel;
    logic [N_CH-1:0]       ch_sel;
    logic [N_CH-1:0][7:0]  ch_rdata;
    logic                  gen_q;
    logic [7:0]            rdata;

    assign blk     = address[ADDR_W-1:4];
    assign offset  = address[3:0];
    assign glb_sel = (blk == '0);

`ifdef PPT_REGFILE_IRQ_EN
    logic [N_CH-1:0] sticky_v;
    logic [N_CH-1:0] irq_mask_q;
    logic            irq_q;
`endif

    // Global enable register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gen_q <= 1'b1;
        end else if (write_enable && glb_sel && offset == G_GCTRL) begin
            gen_q <= data_in[0];
        end
    end

`ifdef PPT_REGFILE_IRQ_EN
    // Interrupt mask and registered interrupt output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (write_enable && glb_sel && offset == G_IRQ_MASK) begin
                irq_mask_q <= data_in[N_CH-1:0];
            end
            irq_q <= |(sticky_v & irq_mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DIV_W-1:0] clk_div_q;
        logic [15:0]      period_q;
        logic [15:0]      width_q;
        logic [15:0]      count_q;
        logic [7:0]       hold_q;
        logic [7:0]       snap_q;
        logic             run_q;
        logic             autostop_q;
        logic             sticky_q;
        logic             done_q;
        logic             wr_sel;
        logic             cfg_wr;
        logic             done_rise;
        logic [15:0]      cnt_done;
        logic [7:0]       rd_byte;

        assign ch_sel[c]  = (blk == BLK_W'(c + 1));
        assign wr_sel     = write_enable & ch_sel[c];
        assign cfg_wr     = wr_sel & ~ch_run[c];
        assign done_rise  = ch_done[c] & ~done_q;
        assign cnt_done   = ch_count_done[c*16 +: 16];

        // Config fields: low bytes park in the holding byte, high byte commits the 16-bit value
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                clk_div_q <= DIV_W'(9);
                period_q  <= 16'd128;
                width_q   <= 16'd1;
                count_q   <= 16'd16;
                hold_q    <= '0;
            end else if (cfg_wr) begin
                case (offset)
                    OFF_CLK_DIV:  clk_div_q <= data_in[DIV_W-1:0];
                    OFF_PERIOD_L,
                    OFF_WIDTH_L,
                    OFF_COUNT_L:  hold_q    <= data_in;
                    OFF_PERIOD_H: period_q  <= {data_in, hold_q};
                    OFF_WIDTH_H:  width_q   <= {data_in, hold_q};
                    OFF_COUNT_H:  count_q   <= {data_in, hold_q};
                    default: ;
                endcase
            end
        end

        // Control, done-edge tracking, sticky flag and count snapshot
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                run_q      <= 1'b0;
                autostop_q <= 1'b0;
                sticky_q   <= 1'b0;
                done_q     <= 1'b0;
                snap_q     <= '0;
            end else begin
                done_q <= ch_done[c];
                // A host CTRL write in the auto-stop cycle takes priority
                if (wr_sel && offset == OFF_CTRL) begin
                    run_q      <= data_in[0];
                    autostop_q <= data_in[1];
                end else if (done_rise && autostop_q) begin
                    run_q <= 1'b0;
                end
                // Set wins over a coincident W1C
                if (done_rise) begin
                    sticky_q <= 1'b1;
                end else if (wr_sel && offset == OFF_STATUS && data_in[1]) begin
                    sticky_q <= 1'b0;
                end
                if (read_enable && ch_sel[c] && offset == OFF_CDONE_L) begin
                    snap_q <= cnt_done[15:8];
                end
            end
        end

        // Channel read byte
        always_comb begin
            rd_byte = '0;
            case (offset)
                OFF_CLK_DIV:  rd_byte = 8'(clk_div_q);
                OFF_PERIOD_L: rd_byte = period_q[7:0];
                OFF_PERIOD_H: rd_byte = period_q[15:8];
                OFF_WIDTH_L:  rd_byte = width_q[7:0];
                OFF_WIDTH_H:  rd_byte = width_q[15:8];
                OFF_COUNT_L:  rd_byte = count_q[7:0];
                OFF_COUNT_H:  rd_byte = count_q[15:8];
                OFF_CTRL:     rd_byte = {6'b0, autostop_q, run_q};
                OFF_CDONE_L:  rd_byte = cnt_done[7:0];
                OFF_CDONE_H:  rd_byte = snap_q;
                OFF_STATUS:   rd_byte = {6'b0, sticky_q, ch_done[c]};
                default:      rd_byte = '0;
            endcase
        end

        assign ch_rdata[c]                = rd_byte;
        assign ch_run[c]                  = run_q & gen_q;
        assign ch_clk_div[c*DIV_W +: DIV_W] = clk_div_q;
        assign ch_period[c*16 +: 16]      = period_q;
        assign ch_width[c*16 +: 16]       = width_q;
        assign ch_count[c*16 +: 16]       = count_q;
`ifdef PPT_REGFILE_IRQ_EN
        assign sticky_v[c]                = sticky_q;
`endif
    end

    // Read data mux across global block and channel blocks
    always_comb begin
        rdata = '0;
        if (glb_sel) begin
            case (offset)
                G_ID:       rdata = {4'hA, 4'(N_CH)};
                G_GCTRL:    rdata = {7'b0, gen_q};
`ifdef PPT_REGFILE_IRQ_EN
                G_IRQ_MASK: rdata = 8'(irq_mask_q);
                G_IRQ_STAT: rdata = 8'(sticky_v);
`endif
                default:    rdata = '0;
            endcase
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (ch_sel[c]) begin
                    rdata = ch_rdata[c];
                end
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out <= '0;
        end else begin
            data_out <= rdata;
        end
    end

endmodule

// File: tb/tb_ppt_regfile_mc.sv
// tb_ppt_regfile_mc: scoreboard bench for ppt_regfile_mc (N_CH=2, ADDR_W=6, DIV_W=5).
// Build with PPT_REGFILE_IRQ_EN defined to exercise the interrupt path.
module tb_ppt_regfile_mc;

    logic        clk;
    logic        rstn;
    logic [5:0]  address;
    logic [7:0]  data_in;
    logic        write_enable;
    logic        read_enable;
    logic [7:0]  data_out;
    logic [9:0]  ch_clk_div;
    logic [31:0] ch_period;
    logic [31:0] ch_width;
    logic [31:0] ch_count;
    logic [1:0]  ch_run;
    logic [31:0] ch_count_done;
    logic [1:0]  ch_done;
    logic        irq;

    typedef struct {
        string      nm;
        logic [7:0] exp;
    } sb_t;

    sb_t sb[$];
    int  vecs = 0;
    int  miss = 0;

    ppt_regfile_mc #(.N_CH(2), .ADDR_W(6), .DIV_W(5)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .address       (address),
        .data_in       (data_in),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .data_out      (data_out),
        .ch_clk_div    (ch_clk_div),
        .ch_period     (ch_period),
        .ch_width      (ch_width),
        .ch_count      (ch_count),
        .ch_run        (ch_run),
        .ch_count_done (ch_count_done),
        .ch_done       (ch_done),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    // Drive a read address, queue its expected byte, return just after the capturing edge
    task automatic rd(input logic [5:0] a, input logic re, input string nm, input logic [7:0] exp);
        @(negedge clk);
        address     = a;
        read_enable = re;
        sb.push_back('{nm, exp});
        @(posedge clk);
        #1;
        read_enable = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] ra [10] = '{6'h00, 6'h10, 6'h11, 6'h12, 6'h17, 6'h01, 6'h04, 6'h30, 6'h21, 6'h1B};
        logic [7:0] rx [10] = '{8'hA2, 8'h09, 8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h00};
        sb_t e;
        rstn = 1'b0; address = '0; data_in = '0; write_enable = 1'b0; read_enable = 1'b0;
        ch_count_done = '0; ch_done = '0;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (ch_run !== 2'b00) begin $display("FAIL rst_run got %b exp 00", ch_run); miss++; end
        vecs++; if (irq !== 1'b0) begin $display("FAIL rst_irq got %b exp 0", irq); miss++; end
        vecs++; if (data_out !== 8'h00) begin $display("FAIL rst_dout got %h exp 00", data_out); miss++; end
        vecs++; if (ch_period !== {16'd128, 16'd128}) begin $display("FAIL rst_period got %h exp 00800080", ch_period); miss++; end
        vecs++; if (ch_clk_div !== {5'd9, 5'd9}) begin $display("FAIL rst_clkdiv got %h exp 129", ch_clk_div); miss++; end
        vecs++; if (ch_width !== {16'd1, 16'd1}) begin $display("FAIL rst_width got %h exp 00010001", ch_width); miss++; end
        vecs++; if (ch_count !== {16'd16, 16'd16}) begin $display("FAIL rst_count got %h exp 00100010", ch_count); miss++; end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd(ra[i], 1'b0, $sformatf("rst_rd_%h", ra[i]), rx[i]);
            e = sb.pop_front();
            vecs++;
            if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        end
    endtask

    task automatic test_atomic();
        sb_t e;
        wr(6'h13, 8'h34);
        vecs++; if (ch_width[15:0] !== 16'h0001) begin $display("FAIL atomic_half got %h exp 0001", ch_width[15:0]); miss++; end
        wr(6'h14, 8'h12);
        vecs++; if (ch_width[15:0] !== 16'h1234) begin $display("FAIL atomic_commit got %h exp 1234", ch_width[15:0]); miss++; end
        vecs++; if (ch_width[31:16] !== 16'h0001) begin $display("FAIL atomic_ch1_width got %h exp 0001", ch_width[31:16]); miss++; end
        wr(6'h21, 8'hCD);
        wr(6'h22, 8'hAB);
        vecs++; if (ch_period[31:16] !== 16'hABCD) begin $display("FAIL atomic_ch1_period got %h exp abcd", ch_period[31:16]); miss++; end
        wr(6'h1B, 8'hFF);
        wr(6'h3F, 8'hFF);
        rd(6'h1B, 1'b0, "reserved_rd", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h14, 1'b0, "width_h_rd", 8'h12);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
    endtask

    task automatic test_protect_autostop();
        sb_t e;
        wr(6'h17, 8'h03);
        vecs++; if (ch_run !== 2'b01) begin $display("FAIL run_on got %b exp 01", ch_run); miss++; end
        wr(6'h11, 8'h55);
        wr(6'h12, 8'h66);
        wr(6'h10, 8'h03);
        vecs++; if (ch_period[15:0] !== 16'h0080) begin $display("FAIL protect_period got %h exp 0080", ch_period[15:0]); miss++; end
        vecs++; if (ch_clk_div[4:0] !== 5'd9) begin $display("FAIL protect_clkdiv got %h exp 09", ch_clk_div[4:0]); miss++; end
        @(negedge clk);
        ch_done[0] = 1'b1;
        @(posedge clk);
        #1;
        vecs++; if (ch_run[0] !== 1'b0) begin $display("FAIL autostop got %b exp 0", ch_run[0]); miss++; end
        rd(6'h1A, 1'b0, "status_done", 8'h03);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h17, 1'b0, "ctrl_after_stop", 8'h02);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        @(negedge clk);
        ch_done[0] = 1'b0;
        rd(6'h1A, 1'b0, "status_sticky", 8'h02);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        wr(6'h1A, 8'h02);
        rd(6'h1A, 1'b0, "status_w1c", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        // Holding byte must not have taken the protected 0x55
        wr(6'h12, 8'h00);
        vecs++; if (ch_period[15:0] !== 16'h0034) begin $display("FAIL hold_protect got %h exp 0034", ch_period[15:0]); miss++; end
        // CTRL write coincident with an auto-stop edge keeps the written value
        wr(6'h17, 8'h03);
        @(negedge clk);
        address = 6'h17; data_in = 8'h03; write_enable = 1'b1; ch_done[0] = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        vecs++; if (ch_run[0] !== 1'b1) begin $display("FAIL host_wins got %b exp 1", ch_run[0]); miss++; end
        ch_done[0] = 1'b0;
        wr(6'h17, 8'h00);
        wr(6'h1A, 8'h02);
    endtask

    task automatic test_snapshot();
        sb_t e;
        ch_count_done[15:0]  = 16'h01FF;
        ch_count_done[31:16] = 16'hBEEF;
        rd(6'h18, 1'b1, "cdone_l", 8'hFF);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        ch_count_done[15:0] = 16'h0200;
        rd(6'h19, 1'b1, "cdone_h_snap", 8'h01);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h29, 1'b0, "ch1_snap_not_live", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h18, 1'b0, "cdone_l_no_strobe", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h19, 1'b0, "snap_held", 8'h01);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
    endtask

    task automatic test_gen();
        sb_t e;
        wr(6'h17, 8'h01);
        vecs++; if (ch_run !== 2'b01) begin $display("FAIL gen_run_on got %b exp 01", ch_run); miss++; end
        wr(6'h01, 8'h00);
        vecs++; if (ch_run !== 2'b00) begin $display("FAIL gen_off got %b exp 00", ch_run); miss++; end
        rd(6'h17, 1'b0, "gen_off_ctrl", 8'h01);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h01, 1'b0, "gctrl_rd", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        wr(6'h01, 8'h01);
        vecs++; if (ch_run !== 2'b01) begin $display("FAIL gen_resume got %b exp 01", ch_run); miss++; end
        wr(6'h17, 8'h00);
    endtask

`ifdef PPT_REGFILE_IRQ_EN
    task automatic test_irq();
        sb_t e;
        wr(6'h02, 8'h01);
        rd(6'h02, 1'b0, "irq_mask_rd", 8'h01);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        @(negedge clk);
        ch_done[0] = 1'b1;
        @(posedge clk); #1;
        vecs++; if (irq !== 1'b0) begin $display("FAIL irq_latency got %b exp 0", irq); miss++; end
        @(posedge clk); #1;
        vecs++; if (irq !== 1'b1) begin $display("FAIL irq_set got %b exp 1", irq); miss++; end
        @(negedge clk);
        ch_done[0] = 1'b0;
        rd(6'h03, 1'b0, "irq_stat", 8'h01);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        wr(6'h1A, 8'h02);
        vecs++; if (irq !== 1'b1) begin $display("FAIL irq_hold got %b exp 1", irq); miss++; end
        @(posedge clk); #1;
        vecs++; if (irq !== 1'b0) begin $display("FAIL irq_clear got %b exp 0", irq); miss++; end
        @(negedge clk);
        address = 6'h1A; data_in = 8'h02; write_enable = 1'b1; ch_done[0] = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        rd(6'h1A, 1'b0, "set_beats_w1c", 8'h03);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        ch_done[0] = 1'b0;
        wr(6'h1A, 8'h02);
        @(negedge clk);
        ch_done[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (irq !== 1'b0) begin $display("FAIL irq_unmasked got %b exp 0", irq); miss++; end
        rd(6'h03, 1'b0, "irq_stat_ch1", 8'h02);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        ch_done[1] = 1'b0;
        wr(6'h2A, 8'h02);
    endtask
`else
    task automatic test_irq();
        sb_t e;
        wr(6'h02, 8'hFF);
        rd(6'h02, 1'b0, "irq_mask_absent", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        @(negedge clk);
        ch_done[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (irq !== 1'b0) begin $display("FAIL irq_tied got %b exp 0", irq); miss++; end
        rd(6'h03, 1'b0, "irq_stat_absent", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        ch_done[0] = 1'b0;
        wr(6'h1A, 8'h02);
    endtask
`endif

    task automatic test_reset_mid();
        sb_t e;
        wr(6'h21, 8'h11);
        wr(6'h22, 8'h22);
        vecs++; if (ch_period[31:16] !== 16'h2211) begin $display("FAIL mid_period got %h exp 2211", ch_period[31:16]); miss++; end
        wr(6'h27, 8'h01);
        vecs++; if (ch_run !== 2'b10) begin $display("FAIL mid_run got %b exp 10", ch_run); miss++; end
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        vecs++; if (ch_run !== 2'b00) begin $display("FAIL async_run got %b exp 00", ch_run); miss++; end
        vecs++; if (ch_period[31:16] !== 16'h0080) begin $display("FAIL async_period got %h exp 0080", ch_period[31:16]); miss++; end
        @(negedge clk);
        rstn = 1'b1;
        rd(6'h27, 1'b0, "mid_ctrl", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
        rd(6'h19, 1'b0, "mid_snap", 8'h00);
        e = sb.pop_front(); vecs++;
        if (data_out !== e.exp) begin $display("FAIL %s got %h exp %h", e.nm, data_out, e.exp); miss++; end
    endtask

    initial begin
        test_reset();
        test_atomic();
        test_protect_autostop();
        test_snapshot();
        test_gen();
        test_irq();
        test_reset_mid();
        if (sb.size() != 0) begin
            vecs++;
            miss++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
